// File: rtl/decode_stage_if.sv
// Fetch/register-file/execute bundle around the RV32I decode stage.
// The slave modport is the decode stage's view; master is the surrounding pipeline.
interface decode_stage_if;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic [31:0] rf_r1;
    logic [31:0] rf_r2;
    logic        ex_ready;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_illegal;

    modport slave (
        input  if_valid, if_instr, if_pc, rf_r1, rf_r2, ex_ready, flush,
        output id_ready, rf_rs1, rf_rs2, ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd,
               ex_opcode, ex_funct3, ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_illegal
    );

    modport master (
        output if_valid, if_instr, if_pc, rf_r1, rf_r2, ex_ready, flush,
        input  id_ready, rf_rs1, rf_rs2, ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_rd,
               ex_opcode, ex_funct3, ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: field/immediate decode, register-file read, load-use stall,
// and the ID/EX pipeline register with hold, bubble and flush handling.
module decode_stage (
    input logic           clk,
    input logic           reset,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ, FmtSys, FmtBad} fmt_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
    } id_ex_t;

    logic [31:0] instr;
    fmt_e        fmt;
    id_ex_t      dec;
    id_ex_t      ex_d, ex_q;
    logic        use_rs1, use_rs2;
    logic        hazard, adv, id_ready;

    assign instr      = bus.if_instr;
    assign bus.rf_rs1 = instr[19:15];
    assign bus.rf_rs2 = instr[24:20];

    // Any opcode outside the list (including instr[1:0] != 2'b11) is illegal.
    always_comb begin
        case (instr[6:0])
            OpOp:                   fmt = FmtR;
            OpImm, OpLoad, OpJalr:  fmt = FmtI;
            OpStore:                fmt = FmtS;
            OpBranch:               fmt = FmtB;
            OpLui, OpAuipc:         fmt = FmtU;
            OpJal:                  fmt = FmtJ;
            OpSystem:               fmt = FmtSys;
            default:                fmt = FmtBad;
        endcase
    end

    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.pc       = bus.if_pc;
        dec.op1      = bus.rf_r1;
        dec.op2      = bus.rf_r2;
        dec.rd       = instr[11:7];
        dec.opcode   = instr[6:0];
        dec.funct3   = instr[14:12];
        dec.funct7b5 = instr[30];
        case (fmt)
            FmtI:    dec.imm = {{20{instr[31]}}, instr[31:20]};
            FmtS:    dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FmtB:    dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            FmtU:    dec.imm = {instr[31:12], 12'b0};
            FmtJ:    dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
            default: dec.imm = '0;
        endcase
        dec.reg_write = (fmt != FmtS) && (fmt != FmtB) && (fmt != FmtBad) && (dec.rd != 5'd0);
        dec.mem_read  = (instr[6:0] == OpLoad);
        dec.mem_write = (instr[6:0] == OpStore);
        dec.illegal   = (fmt == FmtBad);
    end

    assign use_rs1 = (fmt == FmtR) || (fmt == FmtI) || (fmt == FmtS) || (fmt == FmtB) ||
                     (fmt == FmtSys);
    assign use_rs2 = (fmt == FmtR) || (fmt == FmtS) || (fmt == FmtB);

    // A load in EX can't forward yet; stall a consumer one cycle. x0 never matches.
    assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                    ((use_rs1 && (bus.rf_rs1 == ex_q.rd)) ||
                     (use_rs2 && (bus.rf_rs2 == ex_q.rd)));

    assign adv      = !ex_q.valid || bus.ex_ready;
    assign id_ready = !reset && adv && !hazard && !bus.flush;

    always_comb begin
        ex_d = ex_q;
        if (reset) begin
            ex_d = '0;
        end else if (bus.flush) begin
            ex_d.valid = 1'b0;
        end else if (adv) begin
            if (bus.if_valid && !hazard) begin
                ex_d = dec;
            end else begin
                ex_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        ex_q <= ex_d;
    end

    assign bus.id_ready     = id_ready;
    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_pc        = ex_q.pc;
    assign bus.ex_op1       = ex_q.op1;
    assign bus.ex_op2       = ex_q.op2;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_opcode    = ex_q.opcode;
    assign bus.ex_funct3    = ex_q.funct3;
    assign bus.ex_funct7b5  = ex_q.funct7b5;
    assign bus.ex_reg_write = ex_q.reg_write;
    assign bus.ex_mem_read  = ex_q.mem_read;
    assign bus.ex_mem_write = ex_q.mem_write;
    assign bus.ex_illegal   = ex_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random traffic, all compared
// against a behavioural pipeline model held in this file.
module tb_decode_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_stage_if bus ();
    decode_stage dut (.clk(clk), .reset(reset), .bus(bus));

    logic [31:0] rf [32];
    assign bus.rf_r1 = rf[bus.rf_rs1];
    assign bus.rf_r2 = rf[bus.rf_rs2];

    typedef struct packed {
        logic [31:0] pc, op1, op2, imm;
        logic [4:0]  rd;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [3:0]  flags;  // reg_write, mem_read, mem_write, illegal
    } fields_t;

    int      errors = 0;
    int      checks = 0;
    logic    m_valid, m_known, last_ready, mutate;
    fields_t m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic byte kind(input logic [31:0] i);
        case (i[6:0])
            7'h33:               return "R";
            7'h13, 7'h03, 7'h67: return "I";
            7'h23:               return "S";
            7'h63:               return "B";
            7'h37, 7'h17:        return "U";
            7'h6f:               return "J";
            7'h73:               return "Y";
            default:             return "X";
        endcase
    endfunction

    // Immediate values rebuilt arithmetically from the instruction's weighted fields.
    function automatic logic [31:0] imm_of(input logic [31:0] i);
        int  v;
        byte k;
        k = kind(i);
        v = 0;
        if (k == "I") v = (i[31] ? -2048 : 0) + int'(i[30:20]);
        if (k == "S") v = (i[31] ? -2048 : 0) + int'(i[30:25]) * 32 + int'(i[11:7]);
        if (k == "B") v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 +
                          int'(i[11:8]) * 2;
        if (k == "U") v = int'(i & 32'hFFFF_F000);
        if (k == "J") v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 +
                          int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        return 32'(v);
    endfunction

    task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic rdy, input logic fl, input logic rst);
        byte     k;
        logic    haz, adv, exp_ready, u1, u2, rw;
        fields_t nf;
        @(negedge clk);
        if (mutate) rf[$urandom_range(1, 31)] = $urandom;
        reset = rst;
        bus.if_valid = v;
        bus.if_instr = instr;
        bus.if_pc = pc;
        bus.ex_ready = rdy;
        bus.flush = fl;
        #1;
        k   = kind(instr);
        u1  = (k != "U") && (k != "J") && (k != "X");
        u2  = (k == "R") || (k == "S") || (k == "B");
        adv = !m_valid || rdy;
        haz = m_valid && m.flags[2] && (m.rd != 0) &&
              ((u1 && instr[19:15] == m.rd) || (u2 && instr[24:20] == m.rd));
        exp_ready = !rst && adv && !haz && !fl;
        chk("id_ready", 32'(bus.id_ready), 32'(exp_ready));
        chk("rf_rs", {22'b0, bus.rf_rs2, bus.rf_rs1}, {22'b0, instr[24:20], instr[19:15]});
        last_ready = bus.id_ready;
        rw = (k != "S") && (k != "B") && (k != "X") && (instr[11:7] != 0);
        nf = '{pc: pc, op1: rf[instr[19:15]], op2: rf[instr[24:20]], imm: imm_of(instr),
               rd: instr[11:7], opc: instr[6:0], f3: instr[14:12], f7: instr[30],
               flags: {rw, instr[6:0] == 7'h03 && k != "X", instr[6:0] == 7'h23, k == "X"}};
        if (rst) begin
            m_valid = 0; m = '0; m_known = 1;
        end else if (fl) begin
            m_valid = 0; m_known = 0;
        end else if (adv) begin
            if (v && !haz) begin
                m_valid = 1; m = nf; m_known = 1;
            end else begin
                m_valid = 0; m_known = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
        if (m_known) begin
            chk("ex_pc", bus.ex_pc, m.pc);
            chk("ex_op1", bus.ex_op1, m.op1);
            chk("ex_op2", bus.ex_op2, m.op2);
            chk("ex_imm", bus.ex_imm, m.imm);
            chk("ex_fields", {16'b0, bus.ex_rd, bus.ex_opcode, bus.ex_funct3, bus.ex_funct7b5},
                {16'b0, m.rd, m.opc, m.f3, m.f7});
            chk("ex_flags", {28'b0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                             bus.ex_illegal}, {28'b0, m.flags});
        end
    endtask

    initial begin
        logic [6:0]  ops [10];
        logic [31:0] ri;
        int          pick;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h73};
        reset = 1; bus.if_valid = 0; bus.if_instr = 0; bus.if_pc = 0;
        bus.ex_ready = 0; bus.flush = 0;
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : $urandom;
        m_valid = 0; m = '0; m_known = 0; mutate = 0; last_ready = 0;

        step(0, 32'h0, 32'h0, 0, 0, 1);
        step(1, 32'h00500093, 32'h4, 1, 1, 1);          // reset beats flush and capture
        step(0, 32'h0, 32'h0, 1, 0, 0);
        chk("ready_after_reset", 32'(last_ready), 32'd1);

        step(1, 32'h00500093, 32'h100, 1, 0, 0);        // addi x1, x0, 5
        chk("addi_valid", 32'(bus.ex_valid), 32'd1);
        chk("addi_rd", 32'(bus.ex_rd), 32'd1);
        chk("addi_imm", bus.ex_imm, 32'd5);
        chk("addi_rw", 32'(bus.ex_reg_write), 32'd1);

        step(1, 32'h0000A103, 32'h104, 1, 0, 0);        // lw x2, 0(x1)
        rf[2] = 32'h1234_5678;
        step(1, 32'h002101B3, 32'h108, 1, 0, 0);        // add x3, x2, x2 stalls
        chk("loaduse_stall", 32'(last_ready), 32'd0);
        chk("loaduse_bubble", 32'(bus.ex_valid), 32'd0);
        step(1, 32'h002101B3, 32'h108, 1, 0, 0);
        chk("loaduse_accept", 32'(last_ready), 32'd1);
        chk("loaduse_op1", bus.ex_op1, 32'h1234_5678);
        chk("loaduse_op2", bus.ex_op2, 32'h1234_5678);

        step(1, 32'h00700293, 32'h10C, 1, 0, 0);        // addi x5, x0, 7
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h00100313, 32'h110, 0, 0, 0);
            chk("bp_ready", 32'(last_ready), 32'd0);
            chk("bp_hold_rd", 32'(bus.ex_rd), 32'd5);
            chk("bp_hold_imm", bus.ex_imm, 32'd7);
        end
        step(1, 32'h00100313, 32'h110, 1, 0, 0);
        chk("bp_release_rd", 32'(bus.ex_rd), 32'd6);

        step(1, 32'hFE000EE3, 32'h200, 1, 0, 0);        // bit 7 supplies imm[11]
        step(1, 32'hFE000E63, 32'h204, 1, 0, 0);
        chk("b_imm", bus.ex_imm, 32'hFFFF_F7FC);
        step(1, 32'h0000006F, 32'h208, 1, 0, 0);
        chk("j_imm", bus.ex_imm, 32'h0);
        step(1, 32'h12345037, 32'h20C, 1, 0, 0);
        chk("lui_imm", bus.ex_imm, 32'h1234_5000);

        step(1, 32'h00500093, 32'h300, 1, 1, 0);
        chk("flush_ready", 32'(last_ready), 32'd0);
        chk("flush_valid", 32'(bus.ex_valid), 32'd0);

        step(1, 32'h0000_0000, 32'h304, 1, 0, 0);
        chk("illegal_flag", 32'(bus.ex_illegal), 32'd1);
        chk("illegal_rw", 32'(bus.ex_reg_write), 32'd0);

        step(1, 32'h00500093, 32'h308, 1, 0, 0);
        step(1, 32'h00500093, 32'h30C, 0, 0, 1);
        chk("midreset_valid", 32'(bus.ex_valid), 32'd0);
        chk("midreset_pc", bus.ex_pc, 32'd0);

        mutate = 1;
        for (int n = 0; n < 400; n++) begin
            ri = $urandom;
            pick = $urandom_range(0, 11);
            if (pick < 10) ri[6:0] = ops[pick];
            ri[11:7]  = 5'($urandom_range(0, 3));
            ri[19:15] = 5'($urandom_range(0, 3));
            ri[24:20] = 5'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, ri, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
